// File: rtl/reduce_gate_sweep_if.sv
// rtl/reduce_gate_sweep_if.sv - handshake and sweep-control bundle for reduce_gate_sweep
interface reduce_gate_sweep_if #(
    parameter int N = 4
);
    logic [2:0]   op;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_data;
    logic [N-1:0] out_pattern;
    logic         sweep_start;
    logic         sweep_busy;
    logic         sweep_done;
    logic [N:0]   ones_count;

    // Upstream/downstream side: drives inputs, observes results
    modport master (
        output op, in_valid, in_data, out_ready, sweep_start,
        input  in_ready, out_valid, out_data, out_pattern,
               sweep_busy, sweep_done, ones_count
    );

    // Gate unit side
    modport slave (
        input  op, in_valid, in_data, out_ready, sweep_start,
        output in_ready, out_valid, out_data, out_pattern,
               sweep_busy, sweep_done, ones_count
    );
endinterface

// File: rtl/reduce_gate_sweep.sv
// rtl/reduce_gate_sweep.sv - N-input reduction gate with registered output and exhaustive sweep
module reduce_gate_sweep #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    reduce_gate_sweep_if.slave  bus
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [2:0]   op_q, op_d;
    logic         out_valid_q, out_valid_d;
    logic         out_data_q, out_data_d;
    logic [N-1:0] out_pattern_q, out_pattern_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [N:0]   ones_q, ones_d;

    logic         slot_free;
    logic         sweep_res;

    // Reduction over all N bits; inverted ops are the complements, reserved codes give 0
    function automatic logic gate_f(input logic [2:0] o, input logic [N-1:0] d);
        case (o)
            3'b000:  gate_f = &d;
            3'b001:  gate_f = |d;
            3'b010:  gate_f = ^d;
            3'b011:  gate_f = ~&d;
            3'b100:  gate_f = ~|d;
            3'b101:  gate_f = ~^d;
            default: gate_f = 1'b0;
        endcase
    endfunction

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign sweep_res    = gate_f(op_q, cnt_q);
    assign bus.in_ready = (state_q == IDLE) && slot_free && !bus.sweep_start;

    // Next-state: normal-mode accepts, sweep start, and one pattern per free slot while sweeping
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_pattern_d = out_pattern_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ones_d        = ones_q;

        // A consumed result empties the slot unless something is loaded below
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.sweep_start) begin
                    state_d = SWEEP;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                end else if (bus.in_valid && bus.in_ready) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = gate_f(bus.op, bus.in_data);
                    out_pattern_d = bus.in_data;
                end
            end
            SWEEP: begin
                if (slot_free) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = sweep_res;
                    out_pattern_d = cnt_q;
                    ones_d        = ones_q + {{N{1'b0}}, sweep_res};
                    if (cnt_q == {N{1'b1}}) begin
                        // Last pattern loaded: single pass only, counter is left as is
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any sweep in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= 3'b000;
            out_valid_q   <= 1'b0;
            out_data_q    <= 1'b0;
            out_pattern_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ones_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_pattern_q <= out_pattern_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ones_q        <= ones_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_pattern = out_pattern_q;
    assign bus.sweep_busy  = busy_q;
    assign bus.sweep_done  = done_q;
    assign bus.ones_count  = ones_q;

endmodule

// File: tb/tb_reduce_gate_sweep.sv
// tb/tb_reduce_gate_sweep.sv - directed self-checking bench for reduce_gate_sweep
module tb_reduce_gate_sweep;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    reduce_gate_sweep_if #(.N(N)) bus ();

    reduce_gate_sweep #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit-by-bit reference of the gate truth table
    function automatic int ref_f(input logic [2:0] o, input int p);
        int ones;
        ones = 0;
        for (int b = 0; b < N; b++) ones += (p >> b) & 1;
        case (o)
            3'b000:  return (ones == N) ? 1 : 0;
            3'b001:  return (ones != 0) ? 1 : 0;
            3'b010:  return ones % 2;
            3'b011:  return (ones == N) ? 0 : 1;
            3'b100:  return (ones != 0) ? 0 : 1;
            3'b101:  return 1 - (ones % 2);
            default: return 0;
        endcase
    endfunction

    // mode 0: out_ready held high; 1: out_ready 1,0,0,1 repeating; 2: op change and extra start mid-sweep
    task automatic run_sweep(input logic [2:0] sop, input int exp_ones, input int mode, input string nm);
        int  nexp, last, busy_n, stalls, k;
        bit  fin, pv, pr, pd;
        int  pp;
        logic [2:0] lat;
        bus.op          = sop;
        bus.sweep_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_data     = 4'b0101;
        bus.out_ready   = 1'b1;
        #1;
        check({nm, "_start_in_ready"}, int'(bus.in_ready), 0);
        @(negedge clk);
        bus.sweep_start = 1'b0;
        bus.in_valid    = 1'b0;
        check({nm, "_start_no_load"}, int'(bus.out_valid), 0);
        check({nm, "_ones_cleared"}, int'(bus.ones_count), 0);
        lat = sop; nexp = 0; last = -1; busy_n = 0; stalls = 0; k = 0;
        fin = 0; pv = 0; pr = 1; pd = 0; pp = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.sweep_busy) busy_n++;
            if (pv && !pr) begin
                check({nm, "_hold_pattern"}, int'(bus.out_pattern), pp);
                check({nm, "_hold_data"}, int'(bus.out_data), int'(pd));
            end
            if (bus.out_valid && int'(bus.out_pattern) != last) begin
                check({nm, "_pattern_seq"}, int'(bus.out_pattern), nexp);
                check({nm, "_data"}, int'(bus.out_data), ref_f(lat, nexp));
                last = int'(bus.out_pattern);
                nexp++;
            end
            if (bus.sweep_done) begin
                fin = 1;
                break;
            end
            pr = (mode == 1) ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            if (mode == 2 && k == 5) begin
                bus.op          = 3'b000;
                bus.sweep_start = 1'b1;
                bus.in_valid    = 1'b1;
                #1;
                check({nm, "_mid_in_ready"}, int'(bus.in_ready), 0);
            end else begin
                bus.sweep_start = 1'b0;
                bus.in_valid    = 1'b0;
            end
            if (bus.sweep_busy && bus.out_valid && !pr) stalls++;
            pv = bus.out_valid;
            pp = int'(bus.out_pattern);
            pd = bus.out_data;
            bus.out_ready = pr;
            k++;
            @(negedge clk);
        end
        check({nm, "_done_seen"}, int'(fin), 1);
        check({nm, "_patterns"}, nexp, 16);
        check({nm, "_busy_cycles"}, busy_n, 16 + stalls);
        check({nm, "_ones_count"}, int'(bus.ones_count), exp_ones);
        check({nm, "_busy_low"}, int'(bus.sweep_busy), 0);
        check({nm, "_drain_valid"}, int'(bus.out_valid), 1);
        check({nm, "_drain_pattern"}, int'(bus.out_pattern), 15);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_done_one_cycle"}, int'(bus.sweep_done), 0);
        check({nm, "_drained"}, int'(bus.out_valid), 0);
        check({nm, "_ones_hold"}, int'(bus.ones_count), exp_ones);
    endtask

    initial begin
        bit found;
        n_checks = 0;
        n_errors = 0;
        rst_n           = 1'b0;
        bus.op          = 3'b000;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        bus.sweep_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_pattern", int'(bus.out_pattern), 0);
        check("rst_busy", int'(bus.sweep_busy), 0);
        check("rst_done", int'(bus.sweep_done), 0);
        check("rst_ones", int'(bus.ones_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal mode OR: 0000 -> 0, 0100 -> 1, one cycle after accept
        bus.op       = 3'b001;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0000;
        #1;
        check("or_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        check("or0_valid", int'(bus.out_valid), 1);
        check("or0_data", int'(bus.out_data), 0);
        check("or0_pattern", int'(bus.out_pattern), 0);
        bus.in_data = 4'b0100;
        @(negedge clk);
        check("or4_valid", int'(bus.out_valid), 1);
        check("or4_data", int'(bus.out_data), 1);
        check("or4_pattern", int'(bus.out_pattern), 4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("or_drained", int'(bus.out_valid), 0);

        // Every op by sweep, hand-counted ones out of 16 patterns
        run_sweep(3'b100, 1,  0, "nor");
        run_sweep(3'b000, 1,  0, "and");
        run_sweep(3'b001, 15, 0, "or");
        run_sweep(3'b010, 8,  0, "xor");
        run_sweep(3'b011, 15, 0, "nand");
        run_sweep(3'b101, 8,  0, "xnor");
        run_sweep(3'b110, 0,  0, "rsv6");
        run_sweep(3'b111, 0,  0, "rsv7");
        run_sweep(3'b001, 15, 1, "or_bp");
        run_sweep(3'b001, 15, 2, "or_mid");

        // Reset at pattern 7 abandons the sweep without a done pulse
        bus.op          = 3'b001;
        bus.sweep_start = 1'b1;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid && bus.out_pattern == 4'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("mid_rst_reach7", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_pattern", int'(bus.out_pattern), 0);
        check("mid_rst_busy", int'(bus.sweep_busy), 0);
        check("mid_rst_ones", int'(bus.ones_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_no_done", int'(bus.sweep_done), 0);
        end
        check("post_rst_busy", int'(bus.sweep_busy), 0);
        run_sweep(3'b010, 8, 0, "xor_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/reduce_gate_sweep.md
Name: reduce_gate_sweep

Overview:
Parametrised N-input reduction gate unit. It generalises the fixed 4-input OR/NOR dataflow block to six selectable ops and a registered output with a valid/ready handshake. A built-in exhaustive sweep mode drives all 2^N input patterns through the gate and counts the ones at the output. This lets the whole truth table be checked in hardware without a pattern-driving bench.

Parameters:
N, 4, number of gate inputs; legal range 2..8.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
op  input  3  gate op: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 reserved (result 0).
in_valid  input  1  in_data/op valid in normal mode.
in_ready  output  1  unit accepts normal-mode input this cycle.
in_data  input  N  gate inputs, normal mode.
out_valid  output  1  out_data/out_pattern valid.
out_ready  input  1  downstream accepts the output.
out_data  output  1  registered gate result.
out_pattern  output  N  input pattern that produced out_data.
sweep_start  input  1  request an exhaustive sweep, single-cycle pulse.
sweep_busy  output  1  high while in SWEEP.
sweep_done  output  1  one-cycle pulse at sweep completion.
ones_count  output  N+1  number of 1 results produced in the last/current sweep.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - out_valid=0, out_data=0, out_pattern=0.
  - sweep_busy=0, sweep_done=0, ones_count=0.
  - Internal pattern counter=0, latched op=000.
- Output slot rules:
  - slot_free = !out_valid || out_ready.
  - out_valid clears when out_ready=1 and no new load occurs that cycle.
  - Output registers hold while out_valid=1 && out_ready=0.
- Normal mode (state IDLE):
  - in_ready = slot_free && !sweep_start; combinational.
  - When in_valid && in_ready: next edge loads out_data=f(op,in_data), out_pattern=in_data, out_valid=1.
  - Latency is 1 cycle.
  - Back-to-back throughput is 1/cycle when out_ready stays high.
- Gate function f: reduction of all N bits. NAND/NOR/XNOR are bitwise inverses of AND/OR/XOR. Reserved ops yield 0.
- FSM states: IDLE, SWEEP.
- IDLE -> SWEEP on sweep_start. That edge:
  - latches op into op_q;
  - clears the counter and ones_count;
  - sets sweep_busy=1.
  - sweep_start has priority over a simultaneous in_valid, which is not accepted (in_ready=0).
- In SWEEP:
  - in_ready=0; in_valid is ignored.
  - op changes are ignored; op_q is used.
  - sweep_start is ignored.
- Each SWEEP cycle with slot_free:
  - loads out_data=f(op_q,counter), out_pattern=counter, out_valid=1;
  - adds the result bit to ones_count;
  - increments the counter.
  - Stalled cycles (slot not free) change nothing.
- When counter = 2^N-1 is loaded:
  - next state is IDLE;
  - sweep_busy falls on the same edge;
  - sweep_done=1 for exactly that one following cycle.
  - The counter does not wrap into a second pass.
- ones_count:
  - width N+1, so 2^N is representable;
  - holds its final value in IDLE until the next sweep_start clears it.
- Sweep length: 2^N load cycles minimum. Stalls extend it one cycle each.
- Reset mid-sweep:
  - immediate return to IDLE with all reset values;
  - no sweep_done pulse;
  - the partial ones_count is discarded.
- Last-result drain: the final pattern's result remains in the output register with out_valid=1 after sweep_done until it is consumed.

Test Plan:
- Reset and normal OR: N=4, reset, then op=001 with in_data=0000 and then 0100, out_ready=1 -> outputs 0 then 1 one cycle after each accept; out_pattern matches; all outputs 0 during reset.
- Full truth table, NOR: N=4, op=100, sweep_start pulse, out_ready=1 -> out_pattern steps 0..15 on consecutive cycles with out_data=1 only at 0000; sweep_busy high 16 cycles; sweep_done pulses once; ones_count=1.
- All ops by sweep: sweep each op -> AND=1, OR=15, XOR=8, NAND=15, NOR=1, XNOR=8, reserved 110=0.
- Back-pressure: out_ready toggled 1,0,0,1,... during an OR sweep -> no pattern skipped or repeated; outputs held stable while stalled; final ones_count=15; sweep_done delayed by the number of stall cycles.
- Start priority and mid-sweep changes: in_valid=1 together with sweep_start -> in_ready=0 and the input is not loaded. op changed from 001 to 000 mid-sweep -> count still 15. A second sweep_start mid-sweep is ignored.
- Reset mid-sweep: assert rst_n=0 at pattern 7 -> all outputs 0 immediately, no sweep_done pulse. A new sweep then completes with correct counts.
